// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI responder and its users.
package a2d_pkg;

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CHNNL_MSB  = 13;
  localparam int unsigned CHNNL_LSB  = 11;
  localparam int unsigned RES_W      = 12;
  localparam int unsigned CHNNL_W    = CHNNL_MSB - CHNNL_LSB + 1;
  localparam int unsigned NUM_CHNNL  = 1 << CHNNL_W;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned RX_W       = CHNNL_MSB + 1;

  // Channel indices used by the slide-pot interface
  localparam logic [CHNNL_W-1:0] B1  = CHNNL_W'(0);
  localparam logic [CHNNL_W-1:0] LP  = CHNNL_W'(1);
  localparam logic [CHNNL_W-1:0] B3  = CHNNL_W'(2);
  localparam logic [CHNNL_W-1:0] HP  = CHNNL_W'(3);
  localparam logic [CHNNL_W-1:0] B2  = CHNNL_W'(4);
  localparam logic [CHNNL_W-1:0] VOL = CHNNL_W'(7);

  // Response frame: conversion result right-justified, upper nibble zero
  function automatic logic [FRAME_BITS-1:0] resp_word(input logic [RES_W-1:0] val);
    return FRAME_BITS'(val);
  endfunction

endpackage

// File: rtl/a2d_sync_edge.sv
// Multi-flop synchronizer with one extra flop for rise/fall pulse detection.
module a2d_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q      = chain[STAGES-1];
  assign rise_c = q & ~prev;
  assign fall_c = ~q & prev;

endmodule

// File: rtl/a2d_spi_resp.sv
// A2D converter stand-in: answers each SPI command frame with the value of
// the channel named by the previous valid command.
module a2d_spi_resp
  import a2d_pkg::*;
#(
  parameter logic [RES_W-1:0] RST_VAL     = 12'h000,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  input  logic               wr_en,
  input  logic [CHNNL_W-1:0] wr_addr,
  input  logic [RES_W-1:0]   wr_data,
  output logic               cmd_vld,
  output logic [CHNNL_W-1:0] cmd_chnnl,
  output logic               frm_err
);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  // SS_n resets low so a frame already running at reset release is skipped
  a2d_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (SS_n),
    .q      (ss_sync),
    .rise_c (ss_rise),
    .fall_c (ss_fall)
  );

  a2d_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (SCLK),
    .q      (sclk_sync),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  a2d_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (MOSI),
    .q      (mosi_sync),
    .rise_c (mosi_rise_unused),
    .fall_c (mosi_fall_unused)
  );

  logic [RES_W-1:0]      regs [NUM_CHNNL];
  state_t                state;
  logic [FRAME_BITS-1:0] tx_shft;
  logic [RX_W-1:0]       rx_shft;
  logic [CNT_W-1:0]      bit_cnt;

  // Channel-value register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CHNNL); i++) regs[i] <= RST_VAL;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Frame FSM; rx keeps only bits up to the channel MSB, higher bits are don't-care
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx_shft   <= '0;
      rx_shft   <= '0;
      bit_cnt   <= '0;
      cmd_chnnl <= '0;
      cmd_vld   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      cmd_vld <= 1'b0;
      frm_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            tx_shft <= resp_word(regs[cmd_chnnl]);
            rx_shft <= '0;
            bit_cnt <= '0;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state <= IDLE;
            if (bit_cnt == CNT_W'(FRAME_BITS)) begin
              cmd_chnnl <= rx_shft[CHNNL_MSB:CHNNL_LSB];
              cmd_vld   <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
          end else if (sclk_rise) begin
            rx_shft <= {rx_shft[RX_W-2:0], mosi_sync};
            if (bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
          end else if (sclk_fall && (bit_cnt != '0)) begin
            // The master's front-porch fall arrives before any rise and must not shift
            tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO = (state == ACTIVE) ? tx_shft[FRAME_BITS-1] : 1'b0;

  logic sclk_level_unused;
  assign sclk_level_unused = sclk_sync & ss_sync;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench for a2d_spi_resp: directed scenarios plus randomized frames
// against a channel-register / last-command reference model.
module tb_a2d_spi_resp;

  localparam logic [11:0] RST_V = 12'h3C5;
  localparam int          SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, SCLK, MOSI, MISO, wr_en;
  logic [2:0]  wr_addr, cmd_chnnl;
  logic [11:0] wr_data;
  logic        cmd_vld, frm_err;

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0;
  int err_cnt = 0;

  logic [11:0] m_regs [8];
  logic [2:0]  m_ch;

  a2d_spi_resp #(.RST_VAL(RST_V), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cmd_vld   (cmd_vld),
    .cmd_chnnl (cmd_chnnl),
    .frm_err   (frm_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_vld === 1'b1) vld_cnt = vld_cnt + 1;
    if (frm_err === 1'b1) err_cnt = err_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = RST_V;
    m_ch = 3'd0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    m_regs[a] = d;
  endtask

  // Master side of one frame; optional write lands in the responder's load cycle
  task automatic run_frame(input logic [15:0] cmd, input int nbits, input bit coll,
                           input logic [2:0] caddr, input logic [11:0] cdata,
                           output logic [15:0] word, output int dv, output int de);
    int v0, e0;
    v0 = vld_cnt; e0 = err_cnt; word = '0;
    @(negedge clk);
    SS_n = 1'b0;
    if (coll) begin
      repeat (SYNC) @(posedge clk);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = caddr; wr_data = cdata;
      @(negedge clk);
      wr_en = 1'b0;
      tick(1);
    end else begin
      tick(4);
    end
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      tick(6);
      word = {word[14:0], MISO};
      SCLK = 1'b1;
      tick(6);
    end
    SS_n = 1'b1;
    tick(8);
    dv = vld_cnt - v0;
    de = err_cnt - e0;
  endtask

  task automatic test_reset();
    logic [15:0] word; int dv, de;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(3);
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", MISO); end
    checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL reset_cmd_vld: got %b expected 0", cmd_vld); end
    checks++; if (frm_err !== 1'b0) begin errors++; $display("FAIL reset_frm_err: got %b expected 0", frm_err); end
    checks++; if (cmd_chnnl !== 3'd0) begin errors++; $display("FAIL reset_cmd_chnnl: got %0d expected 0", cmd_chnnl); end
    @(negedge clk); rst_n = 1'b1;
    tick(4);
    model_reset();
    run_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0, word, dv, de);
    checks++; if (word !== 16'h03C5) begin errors++; $display("FAIL first_frame_word: got %h expected 03c5", word); end
    checks++; if (dv !== 1) begin errors++; $display("FAIL first_frame_vld: got %0d expected 1", dv); end
  endtask

  task automatic test_basic();
    logic [15:0] word, exp; int dv, de;
    wr(3'd3, 12'hA5C);
    exp = {4'h0, m_regs[m_ch]};
    run_frame(16'h1800, 16, 1'b0, 3'd0, 12'h0, word, dv, de);
    m_ch = 3'd3;
    checks++; if (word !== exp) begin errors++; $display("FAIL basic_f1_word: got %h expected %h", word, exp); end
    checks++; if (dv !== 1 || de !== 0) begin errors++; $display("FAIL basic_f1_pulses: got vld=%0d err=%0d expected 1/0", dv, de); end
    checks++; if (cmd_chnnl !== 3'd3) begin errors++; $display("FAIL basic_f1_chnnl: got %0d expected 3", cmd_chnnl); end
    run_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0, word, dv, de);
    m_ch = 3'd0;
    checks++; if (word !== 16'h0A5C) begin errors++; $display("FAIL basic_f2_word: got %h expected 0a5c", word); end
    checks++; if (dv !== 1 || de !== 0) begin errors++; $display("FAIL basic_f2_pulses: got vld=%0d err=%0d expected 1/0", dv, de); end
    checks++; if (cmd_chnnl !== 3'd0) begin errors++; $display("FAIL basic_f2_chnnl: got %0d expected 0", cmd_chnnl); end
  endtask

  task automatic test_round_robin();
    logic [15:0] word, exp, cmd; int dv, de;
    logic [2:0] seq [7];
    seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd3;
    seq[4] = 3'd4; seq[5] = 3'd7; seq[6] = 3'd1;
    for (int k = 0; k < 6; k++) wr(seq[k], 12'(32'h101 * seq[k]));
    for (int k = 0; k < 7; k++) begin
      cmd = 16'($urandom);
      cmd[13:11] = seq[k];
      exp = {4'h0, m_regs[m_ch]};
      run_frame(cmd, 16, 1'b0, 3'd0, 12'h0, word, dv, de);
      m_ch = seq[k];
      checks++; if (word !== exp) begin errors++; $display("FAIL rr_word_%0d: got %h expected %h", k, word, exp); end
      checks++; if (dv !== 1 || cmd_chnnl !== seq[k]) begin errors++; $display("FAIL rr_cmd_%0d: got vld=%0d chnnl=%0d expected 1/%0d", k, dv, cmd_chnnl, seq[k]); end
    end
    checks++; if (word !== 16'h0707) begin errors++; $display("FAIL rr_ch7: got %h expected 0707", word); end
  endtask

  task automatic test_short_frame();
    logic [15:0] word, exp; int dv, de;
    exp = {4'h0, m_regs[m_ch]};
    run_frame(16'h1000, 15, 1'b0, 3'd0, 12'h0, word, dv, de);
    checks++; if (de !== 1 || dv !== 0) begin errors++; $display("FAIL short_pulses: got vld=%0d err=%0d expected 0/1", dv, de); end
    checks++; if (cmd_chnnl !== m_ch) begin errors++; $display("FAIL short_chnnl: got %0d expected %0d", cmd_chnnl, m_ch); end
    checks++; if (word !== (exp >> 1)) begin errors++; $display("FAIL short_word: got %h expected %h", word, exp >> 1); end
    exp = {4'h0, m_regs[m_ch]};
    run_frame(16'h2000, 16, 1'b0, 3'd0, 12'h0, word, dv, de);
    m_ch = 3'd4;
    checks++; if (word !== exp) begin errors++; $display("FAIL short_next_word: got %h expected %h", word, exp); end
  endtask

  task automatic test_write_collision();
    logic [15:0] word, exp, cmd; int dv, de;
    logic [2:0] ch;
    ch = m_ch;
    cmd = 16'h0000; cmd[13:11] = ch;
    exp = {4'h0, m_regs[ch]};
    run_frame(cmd, 16, 1'b1, ch, 12'hFFF, word, dv, de);
    m_regs[ch] = 12'hFFF;
    checks++; if (word !== exp) begin errors++; $display("FAIL coll_old_word: got %h expected %h", word, exp); end
    run_frame(cmd, 16, 1'b0, 3'd0, 12'h0, word, dv, de);
    checks++; if (word !== 16'h0FFF) begin errors++; $display("FAIL coll_new_word: got %h expected 0fff", word); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] word, cmd; int v0, e0, dv, de;
    cmd = 16'h2800;
    v0 = vld_cnt; e0 = err_cnt;
    @(negedge clk); SS_n = 1'b0; tick(4);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0; MOSI = cmd[15-i]; tick(6);
      SCLK = 1'b1; tick((i < 7) ? 6 : 2);
    end
    rst_n = 1'b0; tick(3);
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso_in_reset: got %b expected 0", MISO); end
    rst_n = 1'b1;
    model_reset();
    word = '0;
    for (int i = 8; i < 16; i++) begin
      SCLK = 1'b0; MOSI = cmd[15-i]; tick(6);
      word = {word[14:0], MISO};
      SCLK = 1'b1; tick(6);
    end
    SS_n = 1'b1; tick(8);
    checks++; if (word !== 16'h0000) begin errors++; $display("FAIL midrst_miso_bits: got %h expected 0000", word); end
    checks++; if (vld_cnt != v0 || err_cnt != e0) begin errors++; $display("FAIL midrst_pulses: got vld=%0d err=%0d expected 0/0", vld_cnt - v0, err_cnt - e0); end
    checks++; if (cmd_chnnl !== 3'd0) begin errors++; $display("FAIL midrst_chnnl: got %0d expected 0", cmd_chnnl); end
    run_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0, word, dv, de);
    checks++; if (word !== {4'h0, RST_V}) begin errors++; $display("FAIL midrst_next_word: got %h expected %h", word, {4'h0, RST_V}); end
    m_ch = 3'd0;
  endtask

  task automatic test_front_porch();
    logic [15:0] word; int dv, de;
    wr(3'd0, 12'h800);
    run_frame(16'h0000, 16, 1'b0, 3'd0, 12'h0, word, dv, de);
    checks++; if (word[15] !== 1'b0 || word[11] !== 1'b1) begin errors++; $display("FAIL porch_bits: got b0=%b b4=%b expected 0/1", word[15], word[11]); end
    checks++; if (word !== 16'h0800) begin errors++; $display("FAIL porch_word: got %h expected 0800", word); end
  endtask

  task automatic test_random();
    logic [15:0] word, exp, cmd, e; int dv, de, nbits, nw;
    for (int k = 0; k < 40; k++) begin
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) wr(3'($urandom), 12'($urandom));
      cmd = 16'($urandom);
      nbits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 34) : 16;
      exp = {4'h0, m_regs[m_ch]};
      run_frame(cmd, nbits, 1'b0, 3'd0, 12'h0, word, dv, de);
      if (nbits == 16) m_ch = cmd[13:11];
      e = (nbits <= 16) ? (exp >> (16 - nbits)) : (exp << (nbits - 16));
      checks++; if (word !== e) begin errors++; $display("FAIL rnd_word_%0d: got %h expected %h (nbits=%0d)", k, word, e, nbits); end
      checks++; if (dv !== ((nbits == 16) ? 1 : 0)) begin errors++; $display("FAIL rnd_vld_%0d: got %0d expected %0d", k, dv, (nbits == 16) ? 1 : 0); end
      checks++; if (de !== ((nbits == 16) ? 0 : 1)) begin errors++; $display("FAIL rnd_err_%0d: got %0d expected %0d", k, de, (nbits == 16) ? 0 : 1); end
      checks++; if (cmd_chnnl !== m_ch) begin errors++; $display("FAIL rnd_chnnl_%0d: got %0d expected %0d", k, cmd_chnnl, m_ch); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_short_frame();
    test_write_collision();
    test_reset_mid_frame();
    test_front_porch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/a2d_spi_resp.md
Name: a2d_spi_resp

Overview:
- Synthesizable SPI responder that plays the A2D converter side of the channel-conversion protocol.
- Receives 16-bit command frames (channel in bits [13:11]) from the SPI master.
- On the next frame, returns the 12-bit value held for the channel named by the previous command.
- Serves as the A2D stand-in for the slide-pot subsystem in FPGA bring-up and full-chip benches. Per-channel values are loaded through a simple write port.

Parameters:
- RST_VAL, 12'h000, reset value of all 8 channel-value registers.
- SYNC_STAGES, 2, synchronizer depth for SS_n/SCLK/MOSI (legal values 2..3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- SS_n  in  1  SPI slave select, active-low.
- SCLK  in  1  SPI clock, idle high.
- MOSI  in  1  command bits from master, MSB first.
- MISO  out  1  response bits to master, MSB first.
- wr_en  in  1  write strobe for the channel-value register file.
- wr_addr  in  3  channel index written.
- wr_data  in  12  value written.
- cmd_vld  out  1  one-clk pulse, a complete 16-bit command was received.
- cmd_chnnl  out  3  channel captured from the last complete command.
- frm_err  out  1  one-clk pulse, frame ended with a bit count other than 16.

Behaviour:
- Reset values: MISO=0, cmd_vld=0, frm_err=0, cmd_chnnl=0, all register-file entries=RST_VAL, state=IDLE, shift registers=0, bit counter=0.
- Synchronization:
  - SS_n, SCLK and MOSI each pass through a SYNC_STAGES flop chain, plus one extra flop for edge detection.
  - SCLK chain resets to 1. SS_n chain resets to 0, so a frame in progress when reset deasserts is ignored until SS_n is seen high.
  - Edge detection runs on the synchronized copies only.
- Register file: 8x12. On wr_en, entry[wr_addr] <= wr_data at the next clk edge. Channels 5 and 6 are writable like any other.
- State machine, IDLE:
  - MISO=0.
  - On a synchronized SS_n fall: load tx_shft <= {4'h0, entry[cmd_chnnl]}, clear bit_cnt and rx_shft, go to ACTIVE.
  - If a write to the same entry happens in the load cycle, tx_shft gets the pre-write value.
- State machine, ACTIVE:
  - MISO = tx_shft[15] combinationally.
  - On a synchronized SCLK rise: rx_shft <= {rx_shft[14:0], MOSI_sync}. bit_cnt increments and saturates at 31.
  - On a synchronized SCLK fall with bit_cnt != 0: tx_shft <= {tx_shft[14:0], 1'b0}. The fall preceding the first rise (master front porch) does not shift.
  - On a synchronized SS_n rise, go to IDLE:
    - If bit_cnt == 16: cmd_chnnl <= rx_shft[13:11] and cmd_vld pulses for 1 clk.
    - Otherwise: frm_err pulses, cmd_chnnl is unchanged.
- Response latency: a frame always returns data for the channel latched at the end of the preceding valid frame. The first frame after reset returns entry[0].
- Ignored bits: command bits [15:14] and [10:0] are ignored; the channel is taken as-is (3 bits, no remapping).
- Simultaneous events in the same synchronized sample:
  - An SS_n rise has priority over SCLK edges; the SCLK edge is dropped.
  - An SCLK rise and fall cannot coincide.
- Edge requirement: SCLK high and low phases must each be at least SYNC_STAGES+2 clk.
- Reset asserted mid-frame: all state returns to reset values immediately. No cmd_vld or frm_err is produced for the aborted frame.

Decomposition:
- Shared package a2d_pkg:
  - state enum {IDLE, ACTIVE}.
  - localparams FRAME_BITS=16, CHNNL_MSB=13, CHNNL_LSB=11, RES_W=12.
  - The channel-index constants used by the slide interface: B1=0, LP=1, B3=2, HP=3, B2=4, VOL=7.
- One sub-module is natural: a2d_sync_edge (parameterized synchronizer chain plus rise/fall pulse outputs), instantiated 3 times (no edge outputs used for MOSI).

Test Plan:
- Write entry[3]=12'hA5C. Frame 1 sends 16'h1800, frame 2 sends 16'h0000. Required: frame 2 MISO word = 16'h0A5C, cmd_vld pulses after each frame, cmd_chnnl=3 after frame 1 and 0 after frame 2.
- Round robin 0,1,2,3,4,7 with entry[n]=12'h100*n+n. Required: each frame returns the previous channel's value, and channel 7 returns 12'h707.
- Frame of 15 SCLK cycles commanding channel 2. Required: frm_err pulse, no cmd_vld, cmd_chnnl keeps its previous value, next frame returns the previous channel's data.
- wr_en to entry[cmd_chnnl] with 12'hFFF in the same clk as the synchronized SS_n fall. Required: the current frame returns the old value and the following frame returns 16'h0FFF.
- Assert rst_n mid-frame (bit 7), release it with SS_n still low, then complete the frame. Required: no cmd_vld/frm_err, MISO=0 until a fresh SS_n fall, next frame returns RST_VAL.
- Front-porch check: SCLK falls 4 clk after SS_n falls, entry[0]=12'h800. Required: the first sampled MISO bit is 0 and bit 4 is 1, with no skipped bit.
